apb_master_ctrl: RTL and testbench
==================================

Name: apb_master_ctrl

Overview:
APB3 initiator that turns a simple command/response interface into APB transfers. It is the requester-side counterpart of the peripheral APB slave ports, such as the UART register block. It is used by bring-up/DMA-style logic and in loopback testbenches to drive peripheral register files. It provides a bounded wait-state timeout so that a hung slave cannot stall the requester.

Parameters:
- APB_DATA_WIDTH, 32, width of PWDATA/PRDATA and command data.
- APB_ADDR_WIDTH, 32, width of PADDR and command address.
- TIMEOUT_CYCLE, 6, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- apb_clk_in  in  1  clock; everything is on the rising edge.
- apb_rstn_in  in  1  reset; synchronous, active-low.
- cmd_valid_in  in  1  command request.
- cmd_ready_out  out  1  command accept; high only in IDLE.
- cmd_addr_in  in  APB_ADDR_WIDTH  transfer address.
- cmd_write_in  in  1  1 = write, 0 = read.
- cmd_wdata_in  in  APB_DATA_WIDTH  write data.
- cmd_strb_in  in  APB_DATA_WIDTH/8  write byte strobes.
- rsp_valid_out  out  1  one-cycle response pulse.
- rsp_rdata_out  out  APB_DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_slverr_out  out  1  slave error or timeout.
- rsp_timeout_out  out  1  transfer was aborted by the timeout.
- apb_addr_out  out  APB_ADDR_WIDTH  PADDR.
- apb_psel_out  out  1  PSEL.
- apb_penable_out  out  1  PENABLE.
- apb_write_out  out  1  PWRITE.
- apb_wdata_out  out  APB_DATA_WIDTH  PWDATA.
- apb_strb_out  out  APB_DATA_WIDTH/8  PSTRB; all-zero on reads.
- apb_rdata_in  in  APB_DATA_WIDTH  PRDATA.
- apb_ready_in  in  1  PREADY.
- apb_slverr_in  in  1  PSLVERR.

Behaviour:
- **Reset:** all outputs are registered. Reset clears every output to 0 except cmd_ready_out, which is 1. State returns to IDLE.
- **FSM states:** IDLE, SETUP, ACCESS.
- **IDLE:**
  - cmd_ready_out = 1.
  - On cmd_valid_in & cmd_ready_out, latch addr, write, wdata and strb (strb is forced to 0 for reads).
  - Next state is SETUP. cmd_ready_out drops on the next cycle.
- **SETUP (one cycle):** psel = 1, penable = 0, address/control/data stable. Next state is ACCESS.
- **ACCESS:**
  - psel = 1, penable = 1. The timeout counter clears on entry.
  - PREADY = 1 means completion: capture PRDATA (reads only) and PSLVERR. Next state is IDLE.
  - PREADY = 0 means stay and increment the counter.
- **Timeout:** if TIMEOUT_CYCLE > 0, the counter equals TIMEOUT_CYCLE-1 and PREADY = 0, the transfer aborts. Next state is IDLE with rsp_slverr = 1, rsp_timeout = 1 and rsp_rdata = 0. ACCESS therefore lasts at most TIMEOUT_CYCLE cycles. If PREADY = 1 on the final cycle, completion takes precedence over the timeout.
- **Response:**
  - rsp_valid_out pulses for exactly one cycle: the first IDLE cycle after completion or abort.
  - The rsp_* data fields hold their value until the next response.
  - There is no response backpressure.
- **APB signal stability:**
  - psel and penable fall in the cycle after completion.
  - PADDR, PWRITE, PWDATA and PSTRB hold their last value while idle.
- **Back-to-back transfers:** minimum 3 cycles per transfer (SETUP, ACCESS, IDLE). A command presented during the response cycle is accepted in that same cycle.
- **Ignored inputs:** cmd_valid_in while busy is ignored (not queued). apb_slverr_in is ignored outside completing ACCESS cycles.
- **Reset mid-transfer:** psel and penable go to 0 on the following edge. No rsp_valid is generated and the in-flight command is dropped.
- **Counter width:** $clog2(TIMEOUT_CYCLE+1), minimum 1. The counter saturates and never wraps.

Decomposition:
- **Package apb_master_pkg:**
  - state enum (IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2);
  - localparam for counter width;
  - response-code constants.
- **Sub-module apb_timeout_cnt:** clear/enable/expire counter, parameterised by TIMEOUT_CYCLE. It is reusable by the slave-side timeout logic.

Test Plan:
- **Write, zero wait:** cmd write addr 0xA0300004, data 0x55AA, strb 0xF at cycle 0, PREADY tied high.
  - psel at cycle 1, penable at cycle 2, rsp_valid at cycle 3, slverr = 0, rdata = 0.
- **Read, 2 wait states:** PREADY low for 2 ACCESS cycles, then high with PRDATA 0xDEADBEEF.
  - rsp_rdata = 0xDEADBEEF, rsp_valid 5 cycles after accept, strb_out = 0.
- **Timeout:** TIMEOUT_CYCLE = 6, PREADY never asserts.
  - Exactly 6 ACCESS cycles, then psel = 0.
  - rsp_valid with slverr = 1, timeout = 1, rdata = 0.
- **Boundary completion and disabled timeout:**
  - TIMEOUT_CYCLE = 6 with PREADY high on the 6th ACCESS cycle gives a normal completion with timeout = 0.
  - TIMEOUT_CYCLE = 0 with a 20-cycle stall must not abort.
- **Slave error, back-to-back:** first transfer returns PSLVERR = 1, giving rsp_slverr = 1, timeout = 0. Second command held valid is accepted in the response cycle, and its SETUP follows immediately.
- **Reset mid-ACCESS:** apb_rstn_in low during ACCESS.
  - Next edge: psel = penable = 0, cmd_ready = 1, no rsp_valid.
  - Busy-time cmd_valid is ignored throughout.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB3 requester: FSM encoding, timeout counter
// sizing and the response codes carried back to the command side.
package apb_master_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t SETUP  = 2'd1;
  localparam state_t ACCESS = 2'd2;

  localparam int DEFAULT_TIMEOUT_CYCLE = 6;

  // Response codes are packed as {timeout, slverr}.
  typedef logic [1:0] rsp_code_t;
  localparam rsp_code_t RSP_OKAY    = 2'b00;
  localparam rsp_code_t RSP_SLVERR  = 2'b01;
  localparam rsp_code_t RSP_TIMEOUT = 2'b11;

  function automatic int timeout_cnt_width(input int timeout_cycle);
    int w;
    w = $clog2(timeout_cycle + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-state counter with clear/enable and an expire flag that
// marks the last permitted cycle; TIMEOUT_CYCLE = 0 never expires.
module apb_timeout_cnt
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLE = DEFAULT_TIMEOUT_CYCLE
) (
  input  logic clk_in,
  input  logic rstn_in,
  input  logic clear_in,
  input  logic enable_in,
  output logic expire_out
);

  localparam int   CNT_W   = timeout_cnt_width(TIMEOUT_CYCLE);
  localparam int   LAST    = (TIMEOUT_CYCLE > 0) ? TIMEOUT_CYCLE - 1 : 0;
  localparam logic ENABLED = (TIMEOUT_CYCLE > 0);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_in) begin
      count_d = '0;
    end else if (enable_in && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_out = ENABLED && (count_q == CNT_W'(LAST));

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3 initiator: turns a valid/ready command into a SETUP/ACCESS transfer
// and returns a one-cycle response, aborting slaves that stall too long.
module apb_master_ctrl
  import apb_master_pkg::*;
#(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLE  = DEFAULT_TIMEOUT_CYCLE
) (
  input  logic                        apb_clk_in,
  input  logic                        apb_rstn_in,
  input  logic                        cmd_valid_in,
  output logic                        cmd_ready_out,
  input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr_in,
  input  logic                        cmd_write_in,
  input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata_in,
  input  logic [APB_DATA_WIDTH/8-1:0] cmd_strb_in,
  output logic                        rsp_valid_out,
  output logic [APB_DATA_WIDTH-1:0]   rsp_rdata_out,
  output logic                        rsp_slverr_out,
  output logic                        rsp_timeout_out,
  output logic [APB_ADDR_WIDTH-1:0]   apb_addr_out,
  output logic                        apb_psel_out,
  output logic                        apb_penable_out,
  output logic                        apb_write_out,
  output logic [APB_DATA_WIDTH-1:0]   apb_wdata_out,
  output logic [APB_DATA_WIDTH/8-1:0] apb_strb_out,
  input  logic [APB_DATA_WIDTH-1:0]   apb_rdata_in,
  input  logic                        apb_ready_in,
  input  logic                        apb_slverr_in
);

  localparam int STRB_W = APB_DATA_WIDTH / 8;

  state_t                    state_d, state_q;
  logic                      cmd_ready_d, cmd_ready_q;
  logic                      psel_d, psel_q;
  logic                      penable_d, penable_q;
  logic [APB_ADDR_WIDTH-1:0] addr_d, addr_q;
  logic                      write_d, write_q;
  logic [APB_DATA_WIDTH-1:0] wdata_d, wdata_q;
  logic [STRB_W-1:0]         strb_d, strb_q;
  logic                      rsp_valid_d, rsp_valid_q;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_d, rsp_rdata_q;
  rsp_code_t                 rsp_code_d, rsp_code_q;
  logic                      expire;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLE(TIMEOUT_CYCLE)
  ) u_timeout_cnt (
    .clk_in    (apb_clk_in),
    .rstn_in   (apb_rstn_in),
    .clear_in  (state_q == SETUP),
    .enable_in ((state_q == ACCESS) && !apb_ready_in),
    .expire_out(expire)
  );

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_code_d  = rsp_code_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_in && cmd_ready_q) begin
          addr_d      = cmd_addr_in;
          write_d     = cmd_write_in;
          wdata_d     = cmd_wdata_in;
          strb_d      = cmd_write_in ? cmd_strb_in : '0;
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // Completion wins over an expiring timeout in the same cycle.
        if (apb_ready_in || expire) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          if (apb_ready_in) begin
            rsp_rdata_d = write_q ? '0 : apb_rdata_in;
            rsp_code_d  = apb_slverr_in ? RSP_SLVERR : RSP_OKAY;
          end else begin
            rsp_rdata_d = '0;
            rsp_code_d  = RSP_TIMEOUT;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge apb_clk_in) begin
    if (!apb_rstn_in) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_code_q  <= RSP_OKAY;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_code_q  <= rsp_code_d;
    end
  end

  assign cmd_ready_out   = cmd_ready_q;
  assign apb_psel_out    = psel_q;
  assign apb_penable_out = penable_q;
  assign apb_addr_out    = addr_q;
  assign apb_write_out   = write_q;
  assign apb_wdata_out   = wdata_q;
  assign apb_strb_out    = strb_q;
  assign rsp_valid_out   = rsp_valid_q;
  assign rsp_rdata_out   = rsp_rdata_q;
  assign rsp_slverr_out  = rsp_code_q[0];
  assign rsp_timeout_out = rsp_code_q[1];

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: one instance with the default timeout
// and a second with the timeout disabled, sharing the APB slave-side inputs.
module tb_apb_master_ctrl;

  logic        clk;
  logic        rstn;
  logic        cmd_valid, cmd_valid0;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  logic        cmd_ready, rsp_valid, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;

  logic        cmd_ready0, rsp_valid0, rsp_slverr0, rsp_timeout0;
  logic [31:0] rsp_rdata0, paddr0, pwdata0;
  logic        psel0, penable0, pwrite0;
  logic [3:0]  pstrb0;

  int checks = 0;
  int errors = 0;

  apb_master_ctrl #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .TIMEOUT_CYCLE(6)) dut (
    .apb_clk_in(clk), .apb_rstn_in(rstn),
    .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
    .cmd_addr_in(cmd_addr), .cmd_write_in(cmd_write),
    .cmd_wdata_in(cmd_wdata), .cmd_strb_in(cmd_strb),
    .rsp_valid_out(rsp_valid), .rsp_rdata_out(rsp_rdata),
    .rsp_slverr_out(rsp_slverr), .rsp_timeout_out(rsp_timeout),
    .apb_addr_out(paddr), .apb_psel_out(psel), .apb_penable_out(penable),
    .apb_write_out(pwrite), .apb_wdata_out(pwdata), .apb_strb_out(pstrb),
    .apb_rdata_in(prdata), .apb_ready_in(pready), .apb_slverr_in(pslverr)
  );

  apb_master_ctrl #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .TIMEOUT_CYCLE(0)) dut0 (
    .apb_clk_in(clk), .apb_rstn_in(rstn),
    .cmd_valid_in(cmd_valid0), .cmd_ready_out(cmd_ready0),
    .cmd_addr_in(cmd_addr), .cmd_write_in(cmd_write),
    .cmd_wdata_in(cmd_wdata), .cmd_strb_in(cmd_strb),
    .rsp_valid_out(rsp_valid0), .rsp_rdata_out(rsp_rdata0),
    .rsp_slverr_out(rsp_slverr0), .rsp_timeout_out(rsp_timeout0),
    .apb_addr_out(paddr0), .apb_psel_out(psel0), .apb_penable_out(penable0),
    .apb_write_out(pwrite0), .apb_wdata_out(pwdata0), .apb_strb_out(pstrb0),
    .apb_rdata_in(prdata), .apb_ready_in(pready), .apb_slverr_in(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic w,
                               input logic [31:0] d, input logic [3:0] s);
    cmd_valid = v;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_strb  = s;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rstn = 1'b0; cmd_valid0 = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    step(); step();
    rstn = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_psel", psel, 0);
    checkOutput("rst_penable", penable, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rdata", rsp_rdata, 0);
    checkOutput("rst_addr", paddr, 0);
    checkOutput("rst_cmd_ready0", cmd_ready0, 1);

    $display("[TB] write, zero wait");
    pready = 1'b1;
    applyStimulus(1'b1, 32'hA030_0004, 1'b1, 32'h0000_55AA, 4'hF);
    step();
    cmd_valid = 1'b0;
    checkOutput("wr_c1_psel", psel, 1);
    checkOutput("wr_c1_penable", penable, 0);
    checkOutput("wr_c1_cmd_ready", cmd_ready, 0);
    checkOutput("wr_c1_addr", paddr, 64'hA030_0004);
    checkOutput("wr_c1_pwrite", pwrite, 1);
    checkOutput("wr_c1_wdata", pwdata, 64'h55AA);
    checkOutput("wr_c1_strb", pstrb, 4'hF);
    step();
    checkOutput("wr_c2_penable", penable, 1);
    checkOutput("wr_c2_rsp_valid", rsp_valid, 0);
    step();
    checkOutput("wr_c3_rsp_valid", rsp_valid, 1);
    checkOutput("wr_c3_slverr", rsp_slverr, 0);
    checkOutput("wr_c3_rdata", rsp_rdata, 0);
    checkOutput("wr_c3_psel", psel, 0);
    checkOutput("wr_c3_cmd_ready", cmd_ready, 1);
    checkOutput("wr_c3_addr_hold", paddr, 64'hA030_0004);
    step();
    checkOutput("wr_c4_rsp_valid", rsp_valid, 0);

    $display("[TB] read, two wait states");
    pready = 1'b0;
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, 32'h0000_1234, 4'hF);
    step();
    cmd_valid = 1'b0;
    checkOutput("rd_c1_strb", pstrb, 0);
    checkOutput("rd_c1_pwrite", pwrite, 0);
    step();
    step();
    checkOutput("rd_c3_penable", penable, 1);
    step();
    pready = 1'b1; prdata = 32'hDEAD_BEEF;
    checkOutput("rd_c4_rsp_valid", rsp_valid, 0);
    checkOutput("rd_c4_penable", penable, 1);
    step();
    pready = 1'b0;
    checkOutput("rd_c5_rsp_valid", rsp_valid, 1);
    checkOutput("rd_c5_rdata", rsp_rdata, 64'hDEAD_BEEF);
    checkOutput("rd_c5_slverr", rsp_slverr, 0);
    step();

    $display("[TB] timeout after six access cycles");
    prdata = 32'hBAD0_BAD0;
    applyStimulus(1'b1, 32'h0000_0020, 1'b0, 32'h0, 4'h0);
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("to_access_%0d", i), {psel, penable, rsp_valid}, 3'b110);
      step();
    end
    checkOutput("to_psel", psel, 0);
    checkOutput("to_penable", penable, 0);
    checkOutput("to_rsp_valid", rsp_valid, 1);
    checkOutput("to_slverr", rsp_slverr, 1);
    checkOutput("to_timeout", rsp_timeout, 1);
    checkOutput("to_rdata", rsp_rdata, 0);
    step();

    $display("[TB] completion on the final access cycle");
    prdata = 32'hCAFE_F00D;
    applyStimulus(1'b1, 32'h0000_0030, 1'b0, 32'h0, 4'h0);
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) step();
    checkOutput("bd_c7_penable", penable, 1);
    pready = 1'b1;
    step();
    pready = 1'b0;
    checkOutput("bd_rsp_valid", rsp_valid, 1);
    checkOutput("bd_timeout", rsp_timeout, 0);
    checkOutput("bd_slverr", rsp_slverr, 0);
    checkOutput("bd_rdata", rsp_rdata, 64'hCAFE_F00D);
    step();

    $display("[TB] slave error then back-to-back read");
    pready = 1'b1; pslverr = 1'b1;
    applyStimulus(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0001, 4'h3);
    step();
    applyStimulus(1'b1, 32'h0000_0044, 1'b0, 32'h0, 4'h0);
    checkOutput("b2b_c1_addr", paddr, 64'h40);
    step();
    checkOutput("b2b_c2_addr", paddr, 64'h40);
    step();
    pslverr = 1'b0; prdata = 32'h0BAD_CAFE;
    checkOutput("b2b_c3_rsp_valid", rsp_valid, 1);
    checkOutput("b2b_c3_slverr", rsp_slverr, 1);
    checkOutput("b2b_c3_timeout", rsp_timeout, 0);
    checkOutput("b2b_c3_rdata", rsp_rdata, 0);
    checkOutput("b2b_c3_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    checkOutput("b2b_c4_psel", {psel, penable}, 2'b10);
    checkOutput("b2b_c4_addr", paddr, 64'h44);
    checkOutput("b2b_c4_rsp_valid", rsp_valid, 0);
    checkOutput("b2b_c4_slverr_hold", rsp_slverr, 1);
    step();
    step();
    checkOutput("b2b_c6_rsp_valid", rsp_valid, 1);
    checkOutput("b2b_c6_slverr", rsp_slverr, 0);
    checkOutput("b2b_c6_rdata", rsp_rdata, 64'h0BAD_CAFE);
    step();

    $display("[TB] disabled timeout, twenty-cycle stall");
    pready = 1'b0; prdata = 32'h600D_F00D;
    applyStimulus(1'b0, 32'h0000_0070, 1'b0, 32'h0, 4'h0);
    cmd_valid0 = 1'b1;
    step();
    cmd_valid0 = 1'b0;
    checkOutput("dis_c1_psel0", psel0, 1);
    checkOutput("dis_c1_main_idle", psel, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("dis_stall_%0d", i), {penable0, rsp_valid0}, 2'b10);
      step();
    end
    pready = 1'b1;
    step();
    pready = 1'b0;
    checkOutput("dis_rsp_valid0", rsp_valid0, 1);
    checkOutput("dis_timeout0", rsp_timeout0, 0);
    checkOutput("dis_slverr0", rsp_slverr0, 0);
    checkOutput("dis_rdata0", rsp_rdata0, 64'h600D_F00D);
    step();

    $display("[TB] reset during access");
    applyStimulus(1'b1, 32'h0000_0050, 1'b1, 32'h1111_2222, 4'hF);
    step();
    applyStimulus(1'b1, 32'h0000_0060, 1'b0, 32'h0, 4'h0);
    step();
    checkOutput("rm_c2_penable", penable, 1);
    checkOutput("rm_c2_addr", paddr, 64'h50);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    cmd_valid = 1'b0;
    checkOutput("rm_psel", psel, 0);
    checkOutput("rm_penable", penable, 0);
    checkOutput("rm_cmd_ready", cmd_ready, 1);
    checkOutput("rm_rsp_valid", rsp_valid, 0);
    step();
    checkOutput("rm_c4_rsp_valid", rsp_valid, 0);
    checkOutput("rm_c4_psel", psel, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
